snn_layer_tm: RTL and testbench
===============================

Name: snn_layer_tm

Overview:
- Time-multiplexed, fully connected leaky integrate-and-fire (LIF) spiking layer. It is the parametrised successor of the fixed 4x3 combinational-weight spiking network.
- Holds a run-time writable signed weight matrix. Processes one input spike vector per "timestep" over N_INPUT accumulation cycles. Emits one registered output spike vector per timestep.
- Adds leak, threshold, refractory period, saturation and a valid/ready step handshake.
- Sits between a spike encoder (or a previous layer) and a spike counter or next layer.

Parameters:
- N_INPUT, 4, number of presynaptic inputs (>=1).
- N_OUTPUT, 3, number of LIF neurons (>=1).
- WEIGHT_WIDTH, 8, signed weight width.
- POT_WIDTH, 16, signed membrane/accumulator width (>= WEIGHT_WIDTH+2).
- THRESHOLD, 20, firing threshold (signed, POT_WIDTH).
- LEAK_SHIFT, 3, leak = v >>> LEAK_SHIFT per timestep (0 disables leak).
- REFRACTORY, 2, timesteps held after a spike (0 = none).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- step_valid  in  1  input spike vector valid.
- step_ready  out  1  high only in IDLE.
- in_spikes  in  N_INPUT  bit k = input k spiked this timestep.
- wr_en  in  1  weight write strobe.
- wr_out_idx  in  max(1,clog2(N_OUTPUT))  target neuron.
- wr_in_idx  in  max(1,clog2(N_INPUT))  source input.
- wr_data  in  WEIGHT_WIDTH  signed weight.
- wr_drop  out  1  one-cycle pulse: write rejected.
- out_valid  out  1  one-cycle pulse: out_spikes valid.
- out_spikes  out  N_OUTPUT  bit j = neuron j fired.
- vmem_flat  out  N_OUTPUT*POT_WIDTH  membrane potentials, neuron j at [j*POT_WIDTH +: POT_WIDTH].

Behaviour:
- Reset (rst low, async):
  - State goes to IDLE.
  - All weights, potentials, accumulators and refractory counters go to 0.
  - Outputs: step_ready=1 once released, out_valid=0, out_spikes=0, wr_drop=0, vmem_flat=0.
  - A reset during ACCUM or UPDATE aborts the timestep; no out_valid is produced.
- FSM states: IDLE, ACCUM, UPDATE.
  - IDLE: a handshake at edge T (step_valid & step_ready) latches in_spikes, clears the accumulators, sets k=0 and moves to ACCUM.
  - ACCUM: edges T+1..T+N_INPUT. At each edge, if latched bit k is set, every acc[j] += sign-extended w[j][k], saturating at the POT_WIDTH signed limits. Then k increments. At k=N_INPUT-1 the next state is UPDATE.
  - UPDATE: edge T+N_INPUT+1. All neurons update in parallel (rules below). out_spikes is registered, out_valid=1 for exactly that one following cycle, state returns to IDLE.
  - Earliest next accept is edge T+N_INPUT+2.
- Neuron update, per j:
  - If ref[j]>0: spike=0, v stays 0, ref decrements.
  - Otherwise: v' = sat(v - (v >>> LEAK_SHIFT) + acc[j]), using arithmetic shift. If v' >= THRESHOLD: spike=1, v=0, ref=REFRACTORY. Else v=v'.
- Saturation: the potential never wraps; it clamps to the POT_WIDTH signed min or max.
- out_spikes holds its value until the next UPDATE. vmem_flat is updated only at UPDATE.
- Weight writes:
  - In IDLE, wr_en writes w[wr_out_idx][wr_in_idx] at the edge.
  - A write and a step accept on the same edge are both taken; the new weight is used by that timestep.
  - In ACCUM or UPDATE the write is ignored and wr_drop pulses for 1 cycle.
  - An out-of-range index is ignored and wr_drop pulses.
- step_valid in a non-IDLE state has no effect; the source must hold it until ready.

Test Plan:
- Defaults; write w[0][0]=5, all other weights 0; 8 steps of in_spikes=4'b0001 -> neuron 0 potentials 5,10,14,18, spike at step 5 (v=0), no spike at steps 6 and 7 (refractory), v=5 at step 8. Neurons 1 and 2 never spike.
- Accept at edge T -> step_ready low from T+1 to T+5; out_valid high only in the cycle after edge T+5; a step_valid held during busy is accepted at the first IDLE edge.
- Override POT_WIDTH=10, THRESHOLD=511; all weights -128; 8 steps of in_spikes=4'b1111 -> neuron 0 potential clamps at -512 with no wrap; no spikes.
- Write issued during ACCUM -> wr_drop pulses 1 cycle; a later step confirms the weight is unchanged. Index wr_out_idx=3 issued in IDLE -> dropped.
- rst asserted mid-ACCUM -> outputs 0 immediately with no clock needed; no out_valid; after release, a step with zero weights gives out_spikes=0.
- In IDLE, wr_en(w[2][1]=25) and a step with in_spikes=4'b0010 on the same edge -> neuron 2 fires in that timestep.

Source files
------------

// File: rtl/snn_layer_tm.sv
// snn_layer_tm
// Time-multiplexed, fully connected leaky integrate-and-fire spiking layer.
// One input spike vector is accepted per timestep. Its set bits are folded
// into one saturating accumulator per neuron, one input column per cycle.
// All neurons then apply leak, threshold and refractory rules in parallel.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous reset, active low
//   step_valid  input spike vector valid
//   step_ready  high only while idle (a step may be accepted)
//   in_spikes   bit k = input k spiked this timestep
//   wr_en       weight write strobe (honoured only while idle)
//   wr_out_idx  target neuron of the write
//   wr_in_idx   source input of the write
//   wr_data     signed weight value
//   wr_drop     one-cycle pulse: a write was rejected
//   out_valid   one-cycle pulse: out_spikes/vmem_flat just updated
//   out_spikes  bit j = neuron j fired in the last timestep
//   vmem_flat   membrane potentials, neuron j at [j*POT_WIDTH +: POT_WIDTH]
module snn_layer_tm #(
    parameter int N_INPUT      = 4,
    parameter int N_OUTPUT     = 3,
    parameter int WEIGHT_WIDTH = 8,
    parameter int POT_WIDTH    = 16,
    parameter int THRESHOLD    = 20,
    parameter int LEAK_SHIFT   = 3,
    parameter int REFRACTORY   = 2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          step_valid,
    output logic                                          step_ready,
    input  logic [N_INPUT-1:0]                            in_spikes,
    input  logic                                          wr_en,
    input  logic [((N_OUTPUT > 1) ? $clog2(N_OUTPUT) : 1)-1:0] wr_out_idx,
    input  logic [((N_INPUT > 1) ? $clog2(N_INPUT) : 1)-1:0]   wr_in_idx,
    input  logic signed [WEIGHT_WIDTH-1:0]                wr_data,
    output logic                                          wr_drop,
    output logic                                          out_valid,
    output logic [N_OUTPUT-1:0]                           out_spikes,
    output logic [N_OUTPUT*POT_WIDTH-1:0]                 vmem_flat
);

    localparam int OUT_IDX_W = (N_OUTPUT > 1) ? $clog2(N_OUTPUT) : 1;
    localparam int IN_IDX_W  = (N_INPUT > 1) ? $clog2(N_INPUT) : 1;
    localparam int K_W       = IN_IDX_W;
    localparam int REF_W     = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;

    localparam logic [OUT_IDX_W:0] OUT_LIMIT = N_OUTPUT[OUT_IDX_W:0];
    localparam logic [IN_IDX_W:0]  IN_LIMIT  = N_INPUT[IN_IDX_W:0];
    localparam logic [K_W-1:0]     K_LAST    = K_W'(N_INPUT - 1);
    localparam logic [REF_W-1:0]   REF_LOAD  = REF_W'(REFRACTORY);
    localparam logic [REF_W-1:0]   REF_ONE   = REF_W'(1);

    localparam logic signed [POT_WIDTH-1:0] THR     = POT_WIDTH'(THRESHOLD);
    localparam logic signed [POT_WIDTH-1:0] POT_MAX = {1'b0, {(POT_WIDTH-1){1'b1}}};
    localparam logic signed [POT_WIDTH-1:0] POT_MIN = {1'b1, {(POT_WIDTH-1){1'b0}}};
    // Limits expressed in the two-bit-wider working width used for sums.
    localparam logic signed [POT_WIDTH+1:0] POT_MAX_X = {3'b000, {(POT_WIDTH-1){1'b1}}};
    localparam logic signed [POT_WIDTH+1:0] POT_MIN_X = {3'b111, {(POT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, UPDATE} state_t;

    state_t                          state;
    state_t                          next_state;
    logic signed [WEIGHT_WIDTH-1:0]  weights [N_OUTPUT][N_INPUT];
    logic signed [POT_WIDTH-1:0]     acc     [N_OUTPUT];
    logic signed [POT_WIDTH-1:0]     vmem    [N_OUTPUT];
    logic [REF_W-1:0]                ref_cnt [N_OUTPUT];
    logic [N_INPUT-1:0]              spikes_q;
    logic [K_W-1:0]                  k;
    logic                            accept;
    logic                            idx_ok;

    logic signed [POT_WIDTH+1:0]     v_ext    [N_OUTPUT];
    logic signed [POT_WIDTH+1:0]     leak_ext [N_OUTPUT];
    logic signed [POT_WIDTH-1:0]     cand     [N_OUTPUT];
    logic signed [POT_WIDTH-1:0]     v_new    [N_OUTPUT];
    logic [REF_W-1:0]                ref_new  [N_OUTPUT];
    logic [N_OUTPUT-1:0]             spike_new;

    function automatic logic signed [POT_WIDTH+1:0] ext_pot(input logic signed [POT_WIDTH-1:0] x);
        return {{2{x[POT_WIDTH-1]}}, x};
    endfunction

    function automatic logic signed [POT_WIDTH+1:0] ext_w(input logic signed [WEIGHT_WIDTH-1:0] x);
        return {{(POT_WIDTH+2-WEIGHT_WIDTH){x[WEIGHT_WIDTH-1]}}, x};
    endfunction

    // Clamp a wide intermediate back into the signed potential range.
    function automatic logic signed [POT_WIDTH-1:0] sat_pot(input logic signed [POT_WIDTH+1:0] x);
        logic signed [POT_WIDTH-1:0] r;
        if (x > POT_MAX_X)
            r = POT_MAX;
        else if (x < POT_MIN_X)
            r = POT_MIN;
        else
            r = x[POT_WIDTH-1:0];
        return r;
    endfunction

    assign accept = step_valid && (state == IDLE);
    assign idx_ok = ({1'b0, wr_out_idx} < OUT_LIMIT) && ({1'b0, wr_in_idx} < IN_LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        step_ready = 1'b0;
        case (state)
            IDLE: begin
                step_ready = 1'b1;
                if (step_valid)
                    next_state = ACCUM;
            end
            ACCUM: begin
                if (k == K_LAST)
                    next_state = UPDATE;
            end
            UPDATE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Weights may only change while idle, so an accumulation pass always
    // sees one consistent matrix; anything else is reported via wr_drop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int o = 0; o < N_OUTPUT; o++)
                for (int i = 0; i < N_INPUT; i++)
                    weights[o][i] <= '0;
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= 1'b0;
            if (wr_en) begin
                if (state == IDLE && idx_ok)
                    weights[wr_out_idx][wr_in_idx] <= wr_data;
                else
                    wr_drop <= 1'b1;
            end
        end
    end

    // Leak/threshold/refractory evaluation for every neuron at once.
    // A leak shift of zero means no leak rather than full decay.
    always_comb begin
        for (int j = 0; j < N_OUTPUT; j++) begin
            v_ext[j]    = ext_pot(vmem[j]);
            leak_ext[j] = '0;
            if (LEAK_SHIFT > 0)
                leak_ext[j] = v_ext[j] >>> LEAK_SHIFT;
            cand[j]      = sat_pot(v_ext[j] - leak_ext[j] + ext_pot(acc[j]));
            v_new[j]     = cand[j];
            ref_new[j]   = '0;
            spike_new[j] = 1'b0;
            if (ref_cnt[j] != '0) begin
                v_new[j]   = '0;
                ref_new[j] = ref_cnt[j] - REF_ONE;
            end else if (cand[j] >= THR) begin
                spike_new[j] = 1'b1;
                v_new[j]     = '0;
                ref_new[j]   = REF_LOAD;
            end
        end
    end

    // Step datapath: latch the vector, walk the input columns, then commit
    // neuron state and the registered outputs in the update cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spikes_q   <= '0;
            k          <= '0;
            out_valid  <= 1'b0;
            out_spikes <= '0;
            for (int j = 0; j < N_OUTPUT; j++) begin
                acc[j]     <= '0;
                vmem[j]    <= '0;
                ref_cnt[j] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        spikes_q <= in_spikes;
                        k        <= '0;
                        for (int j = 0; j < N_OUTPUT; j++)
                            acc[j] <= '0;
                    end
                end
                ACCUM: begin
                    if (spikes_q[k]) begin
                        for (int j = 0; j < N_OUTPUT; j++)
                            acc[j] <= sat_pot(ext_pot(acc[j]) + ext_w(weights[j][k]));
                    end
                    k <= k + K_W'(1);
                end
                UPDATE: begin
                    for (int j = 0; j < N_OUTPUT; j++) begin
                        vmem[j]    <= v_new[j];
                        ref_cnt[j] <= ref_new[j];
                    end
                    out_spikes <= spike_new;
                    out_valid  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    for (genvar j = 0; j < N_OUTPUT; j++) begin : g_flat
        assign vmem_flat[j*POT_WIDTH +: POT_WIDTH] = vmem[j];
    end

endmodule

// File: tb/tb_snn_layer_tm.sv
// Testbench for snn_layer_tm: a default-parameter instance for the main
// behaviour and a narrow-potential instance for saturation. Expected
// step results are queued when stimulus is issued and popped by monitors.
module tb_snn_layer_tm;

    // Clock and shared reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default-parameter DUT signals
    logic        step_valid, step_ready;
    logic [3:0]  in_spikes;
    logic        wr_en;
    logic [1:0]  wr_out_idx, wr_in_idx;
    logic [7:0]  wr_data;
    logic        wr_drop, out_valid;
    logic [2:0]  out_spikes;
    logic [47:0] vmem_flat;

    // Saturation DUT signals
    logic        s_step_valid, s_step_ready;
    logic [3:0]  s_in_spikes;
    logic        s_wr_en;
    logic [1:0]  s_wr_out_idx, s_wr_in_idx;
    logic [7:0]  s_wr_data;
    logic        s_wr_drop, s_out_valid;
    logic [2:0]  s_out_spikes;
    logic [29:0] s_vmem_flat;

    int checks = 0;
    int errors = 0;
    int out_count = 0;
    int sat_count = 0;
    logic [50:0] exp_q[$];
    logic [32:0] sat_q[$];
    logic [50:0] exp_item;
    logic [32:0] sat_item;
    logic [15:0] v_tab [8] = '{16'd5, 16'd10, 16'd14, 16'd18, 16'd0, 16'd0, 16'd0, 16'd5};

    snn_layer_tm dut (
        .clk(clk), .rst(rst),
        .step_valid(step_valid), .step_ready(step_ready), .in_spikes(in_spikes),
        .wr_en(wr_en), .wr_out_idx(wr_out_idx), .wr_in_idx(wr_in_idx), .wr_data(wr_data),
        .wr_drop(wr_drop), .out_valid(out_valid), .out_spikes(out_spikes), .vmem_flat(vmem_flat)
    );

    snn_layer_tm #(.POT_WIDTH(10), .THRESHOLD(511)) dut_sat (
        .clk(clk), .rst(rst),
        .step_valid(s_step_valid), .step_ready(s_step_ready), .in_spikes(s_in_spikes),
        .wr_en(s_wr_en), .wr_out_idx(s_wr_out_idx), .wr_in_idx(s_wr_in_idx), .wr_data(s_wr_data),
        .wr_drop(s_wr_drop), .out_valid(s_out_valid), .out_spikes(s_out_spikes), .vmem_flat(s_vmem_flat)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor for the default DUT: pop one expectation per out_valid pulse
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            out_count++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_out_valid", 64'(out_valid), 64'(0));
            end else begin
                exp_item = exp_q.pop_front();
                checkOutput("out_spikes", 64'(out_spikes), 64'(exp_item[50:48]));
                checkOutput("vmem_flat", 64'(vmem_flat), 64'(exp_item[47:0]));
            end
        end
    end

    // Monitor for the saturation DUT
    always @(negedge clk) begin
        if (s_out_valid === 1'b1) begin
            sat_count++;
            if (sat_q.size() == 0) begin
                checkOutput("sat_unexpected_out_valid", 64'(s_out_valid), 64'(0));
            end else begin
                sat_item = sat_q.pop_front();
                checkOutput("sat_out_spikes", 64'(s_out_spikes), 64'(sat_item[32:30]));
                checkOutput("sat_vmem_flat", 64'(s_vmem_flat), 64'(sat_item[29:0]));
            end
        end
    end

    // Bounded wait until the default DUT has produced the target output count
    task automatic waitOutput(input int target, input string name);
        int n = 0;
        while (out_count < target && n < 40) begin
            @(posedge clk);
            n++;
        end
        checkOutput(name, 64'(out_count), 64'(target));
    endtask

    // One complete timestep on the default DUT with its expected result
    task automatic applyStimulus(input logic [3:0] sp, input logic [2:0] es,
                                 input logic [15:0] v0, input logic [15:0] v1, input logic [15:0] v2);
        int target;
        exp_q.push_back({es, v2, v1, v0});
        target = out_count + 1;
        @(negedge clk);
        step_valid = 1'b1;
        in_spikes  = sp;
        @(posedge clk);
        #1 step_valid = 1'b0;
        waitOutput(target, "step_done");
    endtask

    // Single weight write on the default DUT, checking the drop flag
    task automatic writeWeight(input logic [1:0] oi, input logic [1:0] ii, input logic [7:0] d,
                               input logic exp_drop, input string name);
        @(negedge clk);
        wr_en = 1'b1; wr_out_idx = oi; wr_in_idx = ii; wr_data = d;
        @(posedge clk);
        #1 wr_en = 1'b0;
        checkOutput(name, 64'(wr_drop), 64'(exp_drop));
    endtask

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Main directed sequence
    initial begin
        int target;
        int n;
        rst = 1'b0;
        step_valid = 1'b0; in_spikes = '0; wr_en = 1'b0; wr_out_idx = '0; wr_in_idx = '0; wr_data = '0;
        s_step_valid = 1'b0; s_in_spikes = '0; s_wr_en = 1'b0; s_wr_out_idx = '0; s_wr_in_idx = '0; s_wr_data = '0;

        // Reset state
        #12;
        checkOutput("rst_step_ready", 64'(step_ready), 64'(1));
        checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_out_spikes", 64'(out_spikes), 64'(0));
        checkOutput("rst_wr_drop", 64'(wr_drop), 64'(0));
        checkOutput("rst_vmem_flat", 64'(vmem_flat), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        // LIF trajectory of neuron 0 with a held step_valid; also checks
        // the ready/valid timing of the first two timesteps.
        writeWeight(2'd0, 2'd0, 8'd5, 1'b0, "wr_ok_idle");
        for (int i = 0; i < 8; i++)
            exp_q.push_back({(i == 4) ? 3'b001 : 3'b000, 16'd0, 16'd0, v_tab[i]});
        target = out_count + 8;
        @(negedge clk);
        step_valid = 1'b1;
        in_spikes  = 4'b0001;
        for (int e = 0; e < 48; e++) begin
            @(posedge clk);
            #1;
            if (e < 12) begin
                checkOutput("step_ready_timing", 64'(step_ready), 64'((e % 6) == 5));
                checkOutput("out_valid_timing", 64'(out_valid), 64'((e % 6) == 5));
            end
        end
        step_valid = 1'b0;
        waitOutput(target, "lif_steps_done");

        // Write during ACCUM is dropped and the weight is left unchanged
        exp_q.push_back({3'b000, 16'd0, 16'd0, 16'd10});
        target = out_count + 1;
        @(negedge clk);
        step_valid = 1'b1;
        in_spikes  = 4'b0001;
        @(posedge clk);
        #1 step_valid = 1'b0;
        writeWeight(2'd0, 2'd0, 8'd100, 1'b1, "wr_drop_accum");
        @(posedge clk);
        #1 checkOutput("wr_drop_pulse_end", 64'(wr_drop), 64'(0));
        waitOutput(target, "drop_step_done");
        applyStimulus(4'b0001, 3'b000, 16'd14, 16'd0, 16'd0);

        // Out-of-range neuron index is dropped even while idle
        writeWeight(2'd3, 2'd0, 8'd50, 1'b1, "wr_drop_index");
        @(posedge clk);
        #1 checkOutput("wr_drop_index_end", 64'(wr_drop), 64'(0));

        // Write and step accept on the same edge: new weight used at once
        exp_q.push_back({3'b100, 16'd0, 16'd0, 16'd13});
        target = out_count + 1;
        @(negedge clk);
        wr_en = 1'b1; wr_out_idx = 2'd2; wr_in_idx = 2'd1; wr_data = 8'd25;
        step_valid = 1'b1; in_spikes = 4'b0010;
        @(posedge clk);
        #1 wr_en = 1'b0;
        step_valid = 1'b0;
        checkOutput("wr_same_edge", 64'(wr_drop), 64'(0));
        waitOutput(target, "same_edge_done");

        // Asynchronous reset in the middle of ACCUM aborts the step
        @(negedge clk);
        step_valid = 1'b1;
        in_spikes  = 4'b0001;
        @(posedge clk);
        #1 step_valid = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checkOutput("amid_vmem_flat", 64'(vmem_flat), 64'(0));
        checkOutput("amid_out_spikes", 64'(out_spikes), 64'(0));
        checkOutput("amid_out_valid", 64'(out_valid), 64'(0));
        checkOutput("amid_step_ready", 64'(step_ready), 64'(1));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(posedge clk);
        applyStimulus(4'b1111, 3'b000, 16'd0, 16'd0, 16'd0);

        // Saturation: every weight -128 on a 10-bit potential
        for (int o = 0; o < 3; o++) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                s_wr_en = 1'b1; s_wr_out_idx = 2'(o); s_wr_in_idx = 2'(i); s_wr_data = 8'h80;
                @(posedge clk);
                #1 s_wr_en = 1'b0;
            end
        end
        for (int i = 0; i < 8; i++)
            sat_q.push_back({3'b000, 10'h200, 10'h200, 10'h200});
        target = sat_count + 8;
        @(negedge clk);
        s_step_valid = 1'b1;
        s_in_spikes  = 4'b1111;
        repeat (48) @(posedge clk);
        #1 s_step_valid = 1'b0;
        n = 0;
        while (sat_count < target && n < 40) begin
            @(posedge clk);
            n++;
        end
        checkOutput("sat_steps_done", 64'(sat_count), 64'(target));

        // Nothing expected may be left unconsumed
        repeat (4) @(posedge clk);
        checkOutput("exp_q_empty", 64'(exp_q.size()), 64'(0));
        checkOutput("sat_q_empty", 64'(sat_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
